// File: rtl/ascon_perm_ctrl.sv
// Round sequencer for the iterated ASCON permutation datapath.
// Steps a single-round datapath (constant addition, substitution, linear
// diffusion, state register) through p^a (12 rounds) or p^b (6 rounds).
// It drives the round index, the datapath input select and the state
// register enable, and reports completion with a one-cycle done pulse.
// All outputs come straight from registers, so none of them is a
// combinational function of start_i or mode_i.
module ascon_perm_ctrl #(
    parameter int ROUNDS_A = 12,
    parameter int ROUNDS_B = 6,
    parameter int CNT_W    = 4
) (
    input  logic             clock_i,
    input  logic             resetb_i,
    input  logic             start_i,
    input  logic             mode_i,
    output logic             ready_o,
    output logic             busy_o,
    output logic [CNT_W-1:0] round_o,
    output logic             sel_init_o,
    output logic             en_reg_state_o,
    output logic             done_o
);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    // Both permutations end on the same round index; p^b simply starts later.
    localparam logic [CNT_W-1:0] CNT_LAST    = CNT_W'(ROUNDS_A - 1);
    localparam logic [CNT_W-1:0] CNT_START_A = CNT_W'(ROUNDS_A - ROUNDS_A);
    localparam logic [CNT_W-1:0] CNT_START_B = CNT_W'(ROUNDS_A - ROUNDS_B);

    state_t           state_r;
    logic [CNT_W-1:0] cnt_r;
    logic             first_r;
    logic             ready_r;
    logic             busy_r;
    logic             en_r;
    logic             done_r;

    // Round counter start value; mode is only remembered through this value.
    function automatic logic [CNT_W-1:0] cnt_start(input logic mode);
        logic [CNT_W-1:0] val;
        if (mode == 1'b1) begin
            val = CNT_START_B;
        end else begin
            val = CNT_START_A;
        end
        return val;
    endfunction

    // Sequencer FSM: state, round counter, first-round flag and registered outputs.
    always_ff @(posedge clock_i or negedge resetb_i) begin
        if (!resetb_i) begin
            state_r <= ST_IDLE;
            cnt_r   <= '0;
            first_r <= 1'b0;
            ready_r <= 1'b1;
            busy_r  <= 1'b0;
            en_r    <= 1'b0;
            done_r  <= 1'b0;
        end else begin
            case (state_r)
                ST_IDLE: begin
                    if (start_i) begin
                        state_r <= ST_RUN;
                        cnt_r   <= cnt_start(mode_i);
                        first_r <= 1'b1;
                        ready_r <= 1'b0;
                        busy_r  <= 1'b1;
                        en_r    <= 1'b1;
                        done_r  <= 1'b0;
                    end else begin
                        state_r <= ST_IDLE;
                        first_r <= 1'b0;
                        ready_r <= 1'b1;
                        busy_r  <= 1'b0;
                        en_r    <= 1'b0;
                        done_r  <= 1'b0;
                    end
                end
                ST_RUN: begin
                    // The external state is selected for the first round only.
                    first_r <= 1'b0;
                    ready_r <= 1'b0;
                    if (cnt_r == CNT_LAST) begin
                        // Hold cnt on the last index: no wrap-around.
                        state_r <= ST_DONE;
                        busy_r  <= 1'b0;
                        en_r    <= 1'b0;
                        done_r  <= 1'b1;
                    end else begin
                        state_r <= ST_RUN;
                        cnt_r   <= cnt_r + {{(CNT_W-1){1'b0}}, 1'b1};
                        busy_r  <= 1'b1;
                        en_r    <= 1'b1;
                        done_r  <= 1'b0;
                    end
                end
                ST_DONE: begin
                    state_r <= ST_IDLE;
                    first_r <= 1'b0;
                    ready_r <= 1'b1;
                    busy_r  <= 1'b0;
                    en_r    <= 1'b0;
                    done_r  <= 1'b0;
                end
                default: begin
                    // Unreachable encodings recover to a clean IDLE.
                    state_r <= ST_IDLE;
                    cnt_r   <= '0;
                    first_r <= 1'b0;
                    ready_r <= 1'b1;
                    busy_r  <= 1'b0;
                    en_r    <= 1'b0;
                    done_r  <= 1'b0;
                end
            endcase
        end
    end

    assign ready_o        = ready_r;
    assign busy_o         = busy_r;
    assign round_o        = cnt_r;
    assign sel_init_o     = first_r;
    assign en_reg_state_o = en_r;
    assign done_o         = done_r;

endmodule

// File: tb/tb_ascon_perm_ctrl.sv
// Scoreboard bench for ascon_perm_ctrl: the stimulus pushes the expected
// round/done sequence, a monitor pops and compares whenever the controller
// presents a round (en_reg_state_o) or a done pulse. A bench-side ASCON
// round datapath is driven by the controller to check the final state.
module tb_ascon_perm_ctrl;

    logic       clock_i = 1'b0;
    logic       resetb_i;
    logic       start_i;
    logic       mode_i;
    logic       ready_o;
    logic       busy_o;
    logic [3:0] round_o;
    logic       sel_init_o;
    logic       en_reg_state_o;
    logic       done_o;

    int n_checks = 0;
    int n_fail   = 0;

    typedef struct packed {
        logic       is_done;
        logic [3:0] rnd;
        logic       sel;
    } exp_t;

    exp_t exp_q[$];

    logic [319:0] init_state;
    logic [319:0] state_reg;

    ascon_perm_ctrl #(.ROUNDS_A(12), .ROUNDS_B(6), .CNT_W(4)) dut (
        .clock_i        (clock_i),
        .resetb_i       (resetb_i),
        .start_i        (start_i),
        .mode_i         (mode_i),
        .ready_o        (ready_o),
        .busy_o         (busy_o),
        .round_o        (round_o),
        .sel_init_o     (sel_init_o),
        .en_reg_state_o (en_reg_state_o),
        .done_o         (done_o)
    );

    always #5 clock_i = ~clock_i;

    function automatic logic [63:0] ror64(input logic [63:0] v, input int n);
        return (v >> n) | (v << (64 - n));
    endfunction

    // One ASCON round: constant addition, S-box layer, linear diffusion.
    function automatic logic [319:0] ascon_round(input logic [319:0] s, input logic [3:0] r);
        logic [63:0] x0, x1, x2, x3, x4, t0, t1, t2, t3, t4;
        logic [3:0]  hi;
        x0 = s[319:256]; x1 = s[255:192]; x2 = s[191:128]; x3 = s[127:64]; x4 = s[63:0];
        hi = 4'hF - r;
        x2 = x2 ^ {56'd0, hi, r};
        x0 = x0 ^ x4; x4 = x4 ^ x3; x2 = x2 ^ x1;
        t0 = ~x0 & x1; t1 = ~x1 & x2; t2 = ~x2 & x3; t3 = ~x3 & x4; t4 = ~x4 & x0;
        x0 = x0 ^ t1; x1 = x1 ^ t2; x2 = x2 ^ t3; x3 = x3 ^ t4; x4 = x4 ^ t0;
        x1 = x1 ^ x0; x0 = x0 ^ x4; x3 = x3 ^ x2; x2 = ~x2;
        x0 = x0 ^ ror64(x0, 19) ^ ror64(x0, 28);
        x1 = x1 ^ ror64(x1, 61) ^ ror64(x1, 39);
        x2 = x2 ^ ror64(x2, 1)  ^ ror64(x2, 6);
        x3 = x3 ^ ror64(x3, 10) ^ ror64(x3, 17);
        x4 = x4 ^ ror64(x4, 7)  ^ ror64(x4, 41);
        return {x0, x1, x2, x3, x4};
    endfunction

    // Reference permutation over rounds first..11 applied to the init state.
    function automatic logic [319:0] ref_perm(input int first);
        logic [319:0] s;
        s = init_state;
        for (int r = first; r < 12; r++) begin
            s = ascon_round(s, 4'(r));
        end
        return s;
    endfunction

    // Round datapath under control of the sequencer.
    always @(posedge clock_i) begin
        if (en_reg_state_o) begin
            state_reg <= ascon_round(sel_init_o ? init_state : state_reg, round_o);
        end
    end

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic check_state(input string name, input logic [319:0] exp);
        n_checks++;
        if (state_reg !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, state_reg, exp);
        end
    endtask

    // Scoreboard monitor: every round or done cycle must match the next expectation.
    always @(negedge clock_i) begin
        if (resetb_i === 1'b1 && (en_reg_state_o === 1'b1 || done_o === 1'b1)) begin
            if (exp_q.size() == 0) begin
                n_checks++;
                n_fail++;
                $display("FAIL unexpected_output: got en=%0b done=%0b round=%0d expected none",
                         en_reg_state_o, done_o, round_o);
            end else begin
                exp_t e;
                e = exp_q.pop_front();
                check("seq", {57'd0, done_o, round_o, sel_init_o, busy_o, ready_o},
                      {57'd0, e.is_done, e.rnd, e.sel, ~e.is_done, 1'b0});
            end
        end
    end

    task automatic push_run(input logic m);
        int first;
        first = m ? 6 : 0;
        for (int r = first; r < 12; r++) begin
            exp_q.push_back('{is_done: 1'b0, rnd: 4'(r), sel: (r == first)});
        end
        exp_q.push_back('{is_done: 1'b1, rnd: 4'd11, sel: 1'b0});
    endtask

    // Present start for the accepting edge; keep it high when hold is set.
    task automatic issue(input logic m, input bit hold);
        @(posedge clock_i); #1;
        start_i = 1'b1;
        mode_i  = m;
        push_run(m);
        @(posedge clock_i); #1;
        if (!hold) start_i = 1'b0;
    endtask

    // Count cycles (negedges) until done_o, with a bounded budget.
    task automatic wait_done(output int cyc, input bit toggle);
        bit found;
        found = 1'b0;
        cyc = 0;
        while (!found && cyc < 40) begin
            @(negedge clock_i);
            cyc++;
            if (toggle) mode_i = ~mode_i;
            if (done_o === 1'b1) found = 1'b1;
        end
        if (!found) begin
            n_checks++;
            n_fail++;
            $display("FAIL done_timeout: got no done_o within %0d cycles expected done_o", cyc);
        end
    endtask

    initial begin
        int cyc;
        int ndone;
        init_state = {64'h80400c0600000000, 64'h0001020304050607, 64'h08090a0b0c0d0e0f,
                      64'h0001020304050607, 64'h08090a0b0c0d0e0f};
        resetb_i = 1'b0;
        start_i  = 1'b0;
        mode_i   = 1'b0;

        // Reset values
        @(negedge clock_i);
        check("reset_outputs", {58'd0, ready_o, busy_o, round_o[3:0] == 4'd0 ? 1'b0 : 1'b1,
                                sel_init_o, en_reg_state_o, done_o},
              {58'd0, 6'b100000});
        check("reset_round", {60'd0, round_o}, 64'd0);
        @(negedge clock_i);
        resetb_i = 1'b1;

        // p^a: rounds 0..11, done in cycle 13, result matches reference
        issue(1'b0, 1'b0);
        wait_done(cyc, 1'b0);
        check("pa_latency", 64'(cyc), 64'd13);
        check_state("pa_datapath", ref_perm(0));
        @(negedge clock_i);
        check("pa_ready_after", {63'd0, ready_o}, 64'd1);

        // p^b: rounds 6..11, done in cycle 7
        issue(1'b1, 1'b0);
        wait_done(cyc, 1'b0);
        check("pb_latency", 64'(cyc), 64'd7);
        check_state("pb_datapath", ref_perm(6));
        @(negedge clock_i);
        check("pb_ready_after", {63'd0, ready_o}, 64'd1);

        // start held high and mode toggled during the run: ignored
        issue(1'b0, 1'b1);
        wait_done(cyc, 1'b1);
        start_i = 1'b0;
        check("ignore_latency", 64'(cyc), 64'd13);
        @(negedge clock_i);
        check("ignore_ready", {62'd0, ready_o, busy_o}, 64'd2);
        repeat (3) @(negedge clock_i);

        // Back-to-back: p^b then p^a with start present the cycle after done
        issue(1'b1, 1'b0);
        wait_done(cyc, 1'b0);
        check("b2b_first_latency", 64'(cyc), 64'd7);
        check_state("b2b_pb_datapath", ref_perm(6));
        start_i = 1'b1;
        mode_i  = 1'b0;
        push_run(1'b0);
        @(negedge clock_i);
        check("b2b_ready", {63'd0, ready_o}, 64'd1);
        @(posedge clock_i); #1;
        start_i = 1'b0;
        wait_done(cyc, 1'b0);
        check("b2b_second_latency", 64'(cyc), 64'd13);
        check_state("b2b_pa_datapath", ref_perm(0));

        // Reset mid-run: immediate reset values, no done afterwards
        repeat (2) @(negedge clock_i);
        issue(1'b0, 1'b0);
        repeat (4) @(negedge clock_i);
        @(posedge clock_i); #2;
        resetb_i = 1'b0;
        #1;
        check("midrun_reset", {54'd0, ready_o, busy_o, en_reg_state_o, done_o, sel_init_o, round_o, 1'b0},
              {54'd0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 4'd0, 1'b0});
        exp_q.delete();
        @(negedge clock_i);
        resetb_i = 1'b1;
        ndone = 0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clock_i);
            if (done_o === 1'b1) ndone++;
        end
        check("midrun_no_done", 64'(ndone), 64'd0);
        check("midrun_idle", {62'd0, ready_o, busy_o}, 64'd2);

        check("scoreboard_drained", 64'(exp_q.size()), 64'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
